fetch_unit: RTL

//  IF stage of the RV32I core, directly upstream of the instruction memory.

---
 rtl/fetch_unit.sv | 84 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, drives instruction-memory address, and fills the IF/ID register.
// Stops fetching on the self-loop halt opcode or on a misaligned redirect target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INST = 32'h0000_0063
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_inst_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_inst_o,
    output logic        halted_o,
    output logic        misalign_o,
    output logic [31:0] fetch_count_o,
    output logic        dbg_state
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;

    // Flow control: an instruction moves from imem into IF/ID only on an edge
    // where stall_i=0 (the consumer is ready); stall_i=1 holds PC and IF/ID.
    // A redirect overrides a stall and always injects a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            pc            <= RESET_PC;
            id_valid_o    <= 1'b0;
            id_pc_o       <= 32'h0;
            id_inst_o     <= 32'h0;
            halted_o      <= 1'b0;
            misalign_o    <= 1'b0;
            fetch_count_o <= 32'h0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_i) begin
                        id_valid_o <= 1'b0;
                        if (redirect_pc_i[1:0] == 2'b00) begin
                            pc <= redirect_pc_i;
                        end else begin
                            misalign_o <= 1'b1;
                            state      <= HALT;
                        end
                    end else if (!stall_i) begin
                        id_pc_o       <= pc;
                        id_inst_o     <= imem_inst_i;
                        id_valid_o    <= 1'b1;
                        fetch_count_o <= fetch_count_o + 32'd1;
                        if (imem_inst_i == HALT_INST) begin
                            state    <= HALT;
                            halted_o <= 1'b1;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                    end
                end
                HALT: begin
                    // A stalled consumer still has to see the halt instruction.
                    if (!stall_i) begin
                        id_valid_o <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign imem_addr_o = pc;
    assign id_pc4_o    = id_pc_o + 32'd4;
    assign dbg_state   = state;

endmodule
